aq_djpeg_ycbcr_bank_sched: RTL and testbench

//  Ping-pong scheduler for the two 256-entry YCbCr block buffers between IDCT/upsample writer and YCbCr->RGB converter.

---
 rtl/aq_djpeg_ycbcr_bank_sched.sv | 216 +++++++++++++++++++++
 tb/tb_aq_djpeg_ycbcr_bank_sched.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_djpeg_ycbcr_bank_sched.sv
// aq_djpeg_ycbcr_bank_sched
// Ping-pong scheduler for the two 256-entry YCbCr block buffers sitting between the
// IDCT/upsample writer and the YCbCr->RGB converter. Tracks which bank is full, keeps one
// block descriptor per bank, issues one start request per block and frees a bank once the
// converter has read it out and the RAM read latency has drained.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   WrDone/WrBlockX/Y/WrComp   writer finished filling bank WrBank (1-cycle pulse + descriptor)
//   WrBank, WrReady            bank the writer fills next, and whether it is free
//   ConvEnable, ConvRead       start request to / busy indication from the converter
//   ConvBlockX/Y, ConvComp     descriptor of the block being converted
//   RdBank                     bank the converter reads
//   Idle                       both banks free and scheduler idle
//   Overflow, ReqTimeout       sticky error flags
//
// Optional: define AQ_DJPEG_SCHED_STATS_EN to add StatClr (in) and BlockCount (out, 24 bit),
// a wrapping count of released blocks with synchronous clear.
module aq_djpeg_ycbcr_bank_sched #(
   parameter int unsigned BLK_W   = 12,
   parameter int unsigned DRAIN   = 2,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             WrDone,
   input  logic [BLK_W-1:0] WrBlockX,
   input  logic [BLK_W-1:0] WrBlockY,
   input  logic [2:0]       WrComp,
   output logic             WrBank,
   output logic             WrReady,
   output logic             ConvEnable,
   input  logic             ConvRead,
   output logic [BLK_W-1:0] ConvBlockX,
   output logic [BLK_W-1:0] ConvBlockY,
   output logic [2:0]       ConvComp,
   output logic             RdBank,
   output logic             Idle,
   output logic             Overflow,
`ifdef AQ_DJPEG_SCHED_STATS_EN
   input  logic             StatClr,
   output logic [23:0]      BlockCount,
`endif
   output logic             ReqTimeout
);

   typedef enum logic [2:0] {StIdle, StReq, StRun, StDrain, StRel} state_e;

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
   localparam logic [7:0] DrainCnt   = 8'(DRAIN);

   state_e           state_q, state_d;
   logic [1:0]       full_q, full_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [BLK_W-1:0] slot_x_q [2];
   logic [BLK_W-1:0] slot_x_d [2];
   logic [BLK_W-1:0] slot_y_q [2];
   logic [BLK_W-1:0] slot_y_d [2];
   logic [2:0]       slot_c_q [2];
   logic [2:0]       slot_c_d [2];
   logic             conv_en_q, conv_en_d;
   logic [BLK_W-1:0] conv_x_q, conv_x_d;
   logic [BLK_W-1:0] conv_y_q, conv_y_d;
   logic [2:0]       conv_c_q, conv_c_d;
   logic             overflow_q, overflow_d;
   logic             timeout_q, timeout_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             wr_accept;

   always_comb begin
      state_d    = state_q;
      full_d     = full_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      slot_x_d   = slot_x_q;
      slot_y_d   = slot_y_q;
      slot_c_d   = slot_c_q;
      conv_en_d  = conv_en_q;
      conv_x_d   = conv_x_q;
      conv_y_d   = conv_y_q;
      conv_c_d   = conv_c_q;
      overflow_d = overflow_q;
      timeout_d  = timeout_q;
      cnt_d      = cnt_q;

      // WrReady is registered state, so a write landing on the release edge of the same
      // bank is still refused.
      wr_accept = WrDone & ~full_q[wr_ptr_q];
      if (WrDone & full_q[wr_ptr_q]) begin
         overflow_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (full_q[rd_ptr_q]) begin
               state_d   = StReq;
               conv_en_d = 1'b1;
               conv_x_d  = slot_x_q[rd_ptr_q];
               conv_y_d  = slot_y_q[rd_ptr_q];
               conv_c_d  = slot_c_q[rd_ptr_q];
               cnt_d     = '0;
            end
         end
         StReq: begin
            if (ConvRead) begin
               state_d   = StRun;
               conv_en_d = 1'b0;
            end else if (cnt_q != TimeoutCnt) begin
               // Saturates at TimeoutCnt; the request stays asserted regardless.
               cnt_d = cnt_q + 8'd1;
               if (cnt_q + 8'd1 == TimeoutCnt) begin
                  timeout_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (!ConvRead) begin
               cnt_d   = '0;
               state_d = (DRAIN == 0) ? StRel : StDrain;
            end
         end
         StDrain: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == DrainCnt) begin
               state_d = StRel;
            end
         end
         StRel: begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
            state_d          = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // An accepted write never targets the bank released this cycle (that bank is full).
      if (wr_accept) begin
         full_d[wr_ptr_q]   = 1'b1;
         slot_x_d[wr_ptr_q] = WrBlockX;
         slot_y_d[wr_ptr_q] = WrBlockY;
         slot_c_d[wr_ptr_q] = WrComp;
         wr_ptr_d           = ~wr_ptr_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         full_q     <= 2'b00;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         slot_x_q   <= '{default: '0};
         slot_y_q   <= '{default: '0};
         slot_c_q   <= '{default: '0};
         conv_en_q  <= 1'b0;
         conv_x_q   <= '0;
         conv_y_q   <= '0;
         conv_c_q   <= '0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         full_q     <= full_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         slot_x_q   <= slot_x_d;
         slot_y_q   <= slot_y_d;
         slot_c_q   <= slot_c_d;
         conv_en_q  <= conv_en_d;
         conv_x_q   <= conv_x_d;
         conv_y_q   <= conv_y_d;
         conv_c_q   <= conv_c_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
         cnt_q      <= cnt_d;
      end
   end

   assign WrBank     = wr_ptr_q;
   assign WrReady    = ~full_q[wr_ptr_q];
   assign ConvEnable = conv_en_q;
   assign ConvBlockX = conv_x_q;
   assign ConvBlockY = conv_y_q;
   assign ConvComp   = conv_c_q;
   assign RdBank     = rd_ptr_q;
   assign Idle       = (full_q == 2'b00) && (state_q == StIdle);
   assign Overflow   = overflow_q;
   assign ReqTimeout = timeout_q;

`ifdef AQ_DJPEG_SCHED_STATS_EN
   logic [23:0] blk_cnt_q, blk_cnt_d;

   // Counted on entry to StRel; clear wins over a coincident increment.
   always_comb begin
      blk_cnt_d = blk_cnt_q;
      if (StatClr) begin
         blk_cnt_d = '0;
      end else if ((state_d == StRel) && (state_q != StRel)) begin
         blk_cnt_d = blk_cnt_q + 24'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk_cnt_q <= '0;
      end else begin
         blk_cnt_q <= blk_cnt_d;
      end
   end

   assign BlockCount = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aq_djpeg_ycbcr_bank_sched.sv
`timescale 1ns/1ps
module tb_aq_djpeg_ycbcr_bank_sched;
   localparam int unsigned BLK_W   = 12;
   localparam int unsigned DRAIN   = 2;
   localparam int unsigned TIMEOUT = 16;
   localparam int          READ_LEN = 256;
   localparam int          N_STREAM = 10;

   typedef struct packed {
      logic [BLK_W-1:0] x;
      logic [BLK_W-1:0] y;
      logic [2:0]       c;
   } desc_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             WrDone = 1'b0;
   logic [BLK_W-1:0] WrBlockX = '0;
   logic [BLK_W-1:0] WrBlockY = '0;
   logic [2:0]       WrComp = '0;
   logic             WrBank, WrReady, ConvEnable;
   logic             ConvRead = 1'b0;
   logic [BLK_W-1:0] ConvBlockX, ConvBlockY;
   logic [2:0]       ConvComp;
   logic             RdBank, Idle, Overflow, ReqTimeout;
`ifdef AQ_DJPEG_SCHED_STATS_EN
   logic             StatClr = 1'b0;
   logic [23:0]      BlockCount;
`endif

   int vectors = 0;
   int miscompares = 0;

   aq_djpeg_ycbcr_bank_sched #(
      .BLK_W  (BLK_W),
      .DRAIN  (DRAIN),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .WrDone    (WrDone),
      .WrBlockX  (WrBlockX),
      .WrBlockY  (WrBlockY),
      .WrComp    (WrComp),
      .WrBank    (WrBank),
      .WrReady   (WrReady),
      .ConvEnable(ConvEnable),
      .ConvRead  (ConvRead),
      .ConvBlockX(ConvBlockX),
      .ConvBlockY(ConvBlockY),
      .ConvComp  (ConvComp),
      .RdBank    (RdBank),
      .Idle      (Idle),
      .Overflow  (Overflow),
`ifdef AQ_DJPEG_SCHED_STATS_EN
      .StatClr   (StatClr),
      .BlockCount(BlockCount),
`endif
      .ReqTimeout(ReqTimeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      WrDone   = 1'b0;
      ConvRead = 1'b0;
      rst      = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   function automatic desc_t rand_desc();
      desc_t d;
      d.x = BLK_W'($urandom);
      d.y = BLK_W'($urandom);
      d.c = ($urandom_range(0, 1) == 1) ? 3'd3 : 3'd1;
      return d;
   endfunction

   function automatic desc_t cur_desc();
      return {ConvBlockX, ConvBlockY, ConvComp};
   endfunction

   task automatic write_block(input desc_t d);
      WrDone   = 1'b1;
      WrBlockX = d.x;
      WrBlockY = d.y;
      WrComp   = d.c;
      tick();
      WrDone = 1'b0;
   endtask

   // Converter read-out followed by the drain window; returns on the release edge.
   task automatic read_and_drain();
      ConvRead = 1'b1;
      repeat (READ_LEN) tick();
      ConvRead = 1'b0;
      repeat (DRAIN + 2) tick();
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      vectors++;
      if ({WrBank, WrReady, ConvEnable, RdBank, Idle, Overflow, ReqTimeout} !== 7'b0100100)
         $display("FAIL reset_flags: got %b expected 0100100",
                  {WrBank, WrReady, ConvEnable, RdBank, Idle, Overflow, ReqTimeout});
      vectors++;
      if (cur_desc() !== '0)
         $display("FAIL reset_desc: got %h expected 0", cur_desc());
      if ({WrBank, WrReady, ConvEnable, RdBank, Idle, Overflow, ReqTimeout} !== 7'b0100100 ||
          cur_desc() !== '0) miscompares++;
      tick();
      rst = 1'b0;
      tick();
      vectors++;
      if (WrReady !== 1'b1 || Idle !== 1'b1 || ConvEnable !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: WrReady=%b Idle=%b ConvEnable=%b expected 1 1 0",
                  WrReady, Idle, ConvEnable);
      end
   endtask

   task automatic test_single_block();
      desc_t d;
      int    n;
      do_reset();
      d.x = 12'd3;
      d.y = 12'd5;
      d.c = 3'd3;
      write_block(d);
      vectors++;
      if (ConvEnable !== 1'b0 || WrBank !== 1'b1 || Idle !== 1'b0) begin
         miscompares++;
         $display("FAIL single_after_wr: ConvEnable=%b WrBank=%b Idle=%b expected 0 1 0",
                  ConvEnable, WrBank, Idle);
      end
      tick();
      vectors++;
      if (ConvEnable !== 1'b1) begin
         miscompares++;
         $display("FAIL single_en_latency: ConvEnable=%b expected 1", ConvEnable);
      end
      vectors++;
      if (cur_desc() !== d || RdBank !== 1'b0) begin
         miscompares++;
         $display("FAIL single_desc: got %h bank %b expected %h bank 0", cur_desc(), RdBank, d);
      end
      ConvRead = 1'b1;
      tick();
      vectors++;
      if (ConvEnable !== 1'b0) begin
         miscompares++;
         $display("FAIL single_en_drop: ConvEnable=%b expected 0", ConvEnable);
      end
      repeat (READ_LEN - 1) tick();
      ConvRead = 1'b0;
      n = 0;
      while (Idle !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (n != DRAIN + 2) begin
         miscompares++;
         $display("FAIL single_release_lat: got %0d cycles expected %0d", n, DRAIN + 2);
      end
      vectors++;
      if (RdBank !== 1'b1 || WrReady !== 1'b1 || cur_desc() !== d) begin
         miscompares++;
         $display("FAIL single_post: RdBank=%b WrReady=%b desc=%h expected 1 1 %h",
                  RdBank, WrReady, cur_desc(), d);
      end
   endtask

   task automatic test_back_to_back();
      desc_t a, b;
      do_reset();
      a = rand_desc();
      b = rand_desc();
      write_block(a);
      write_block(b);
      vectors++;
      if (WrReady !== 1'b0 || WrBank !== 1'b0 || Overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_full: WrReady=%b WrBank=%b Overflow=%b expected 0 0 0",
                  WrReady, WrBank, Overflow);
      end
      vectors++;
      if (ConvEnable !== 1'b1 || cur_desc() !== a || RdBank !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_first: en=%b desc=%h bank=%b expected 1 %h 0",
                  ConvEnable, cur_desc(), RdBank, a);
      end
      read_and_drain();
      vectors++;
      if (WrReady !== 1'b1 || RdBank !== 1'b1 || ConvEnable !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_release: WrReady=%b RdBank=%b en=%b expected 1 1 0",
                  WrReady, RdBank, ConvEnable);
      end
      tick();
      vectors++;
      if (ConvEnable !== 1'b1 || cur_desc() !== b) begin
         miscompares++;
         $display("FAIL b2b_second: en=%b desc=%h expected 1 %h", ConvEnable, cur_desc(), b);
      end
      read_and_drain();
      vectors++;
      if (Idle !== 1'b1 || Overflow !== 1'b0 || RdBank !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_end: Idle=%b Overflow=%b RdBank=%b expected 1 0 0",
                  Idle, Overflow, RdBank);
      end
   endtask

   task automatic test_overflow();
      desc_t a, b, c, d;
      do_reset();
      a = rand_desc();
      b = rand_desc();
      c = rand_desc();
      d = rand_desc();
      write_block(a);
      write_block(b);
      write_block(c);
      vectors++;
      if (Overflow !== 1'b1 || WrBank !== 1'b0 || WrReady !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_flag: Overflow=%b WrBank=%b WrReady=%b expected 1 0 0",
                  Overflow, WrBank, WrReady);
      end
      vectors++;
      if (cur_desc() !== a) begin
         miscompares++;
         $display("FAIL ovf_desc_a: got %h expected %h", cur_desc(), a);
      end
      ConvRead = 1'b1;
      repeat (READ_LEN) tick();
      ConvRead = 1'b0;
      // Write pulse coincides with the release edge of the same bank: must be refused.
      for (int i = 1; i <= DRAIN + 2; i++) begin
         if (i == DRAIN + 2) begin
            WrDone   = 1'b1;
            WrBlockX = c.x;
            WrBlockY = c.y;
            WrComp   = c.c;
         end
         tick();
         WrDone = 1'b0;
      end
      vectors++;
      if (WrBank !== 1'b0 || WrReady !== 1'b1 || Overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_simul: WrBank=%b WrReady=%b Overflow=%b expected 0 1 1",
                  WrBank, WrReady, Overflow);
      end
      tick();
      vectors++;
      if (ConvEnable !== 1'b1 || cur_desc() !== b || RdBank !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_desc_b: en=%b desc=%h bank=%b expected 1 %h 1",
                  ConvEnable, cur_desc(), RdBank, b);
      end
      write_block(d);
      vectors++;
      if (WrBank !== 1'b1 || WrReady !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_refill: WrBank=%b WrReady=%b expected 1 0", WrBank, WrReady);
      end
      read_and_drain();
      tick();
      vectors++;
      if (ConvEnable !== 1'b1 || cur_desc() !== d || RdBank !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_desc_d: en=%b desc=%h bank=%b expected 1 %h 0",
                  ConvEnable, cur_desc(), RdBank, d);
      end
      read_and_drain();
      vectors++;
      if (Idle !== 1'b1 || Overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_sticky: Idle=%b Overflow=%b expected 1 1", Idle, Overflow);
      end
   endtask

   task automatic test_timeout();
      desc_t a;
      int    n;
      do_reset();
      ConvRead = 1'b1;
      repeat (3) tick();
      ConvRead = 1'b0;
      vectors++;
      if (Idle !== 1'b1 || ConvEnable !== 1'b0 || RdBank !== 1'b0) begin
         miscompares++;
         $display("FAIL spurious_read: Idle=%b en=%b RdBank=%b expected 1 0 0",
                  Idle, ConvEnable, RdBank);
      end
      a = rand_desc();
      write_block(a);
      tick();
      n = 0;
      while (ReqTimeout !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      vectors++;
      if (n != TIMEOUT) begin
         miscompares++;
         $display("FAIL timeout_lat: got %0d cycles expected %0d", n, TIMEOUT);
      end
      repeat (5) tick();
      vectors++;
      if (ConvEnable !== 1'b1 || cur_desc() !== a) begin
         miscompares++;
         $display("FAIL timeout_hold: en=%b desc=%h expected 1 %h", ConvEnable, cur_desc(), a);
      end
      read_and_drain();
      vectors++;
      if (Idle !== 1'b1 || ReqTimeout !== 1'b1 || ConvEnable !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_done: Idle=%b ReqTimeout=%b en=%b expected 1 1 0",
                  Idle, ReqTimeout, ConvEnable);
      end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      write_block(rand_desc());
      write_block(rand_desc());
      ConvRead = 1'b1;
      repeat (50) tick();
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({WrBank, WrReady, ConvEnable, RdBank, Idle, Overflow, ReqTimeout} !== 7'b0100100 ||
          cur_desc() !== '0) begin
         miscompares++;
         $display("FAIL midrun_reset: flags=%b desc=%h expected 0100100 0",
                  {WrBank, WrReady, ConvEnable, RdBank, Idle, Overflow, ReqTimeout}, cur_desc());
      end
      ConvRead = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      vectors++;
      if (Idle !== 1'b1 || ConvEnable !== 1'b0) begin
         miscompares++;
         $display("FAIL midrun_after: Idle=%b en=%b expected 1 0", Idle, ConvEnable);
      end
   endtask

   // Random writer and converter against a FIFO model of the two banks.
   task automatic test_random_stream();
      desc_t q[$];
      desc_t nd;
      int    phase, delay, rd_left, drain_left, written, done;
      bit    armed, do_wr, wb, rb;
      do_reset();
      phase = 0; delay = 0; rd_left = 0; drain_left = 0; written = 0; done = 0;
      armed = 1'b0; wb = 1'b0; rb = 1'b0;
      for (int cyc = 0; cyc < 8000 && done < N_STREAM; cyc++) begin
         do_wr    = (q.size() < 2) && (written < N_STREAM) && ($urandom_range(0, 2) == 0);
         nd       = rand_desc();
         WrDone   = do_wr;
         WrBlockX = nd.x;
         WrBlockY = nd.y;
         WrComp   = nd.c;
         ConvRead = (phase == 2);
         tick();
         WrDone = 1'b0;
         if (do_wr) begin
            q.push_back(nd);
            written++;
            wb = ~wb;
         end
         case (phase)
            0: begin
               vectors++;
               if (ConvEnable !== armed) begin
                  miscompares++;
                  $display("FAIL stream_en: cycle %0d got %b expected %b", cyc, ConvEnable, armed);
               end
               if (armed && ConvEnable === 1'b1) begin
                  vectors++;
                  if (cur_desc() !== q[0]) begin
                     miscompares++;
                     $display("FAIL stream_desc: got %h expected %h", cur_desc(), q[0]);
                  end
                  phase = 1;
                  delay = $urandom_range(0, 3);
               end
            end
            1: begin
               vectors++;
               if (ConvEnable !== 1'b1 || cur_desc() !== q[0]) begin
                  miscompares++;
                  $display("FAIL stream_req: en=%b desc=%h expected 1 %h",
                           ConvEnable, cur_desc(), q[0]);
               end
               if (delay == 0) begin
                  phase   = 2;
                  rd_left = READ_LEN;
               end else begin
                  delay--;
               end
            end
            2: begin
               vectors++;
               if (ConvEnable !== 1'b0 || cur_desc() !== q[0]) begin
                  miscompares++;
                  $display("FAIL stream_run: en=%b desc=%h expected 0 %h",
                           ConvEnable, cur_desc(), q[0]);
               end
               rd_left--;
               if (rd_left == 0) begin
                  phase      = 3;
                  drain_left = DRAIN + 2;
               end
            end
            default: begin
               drain_left--;
               if (drain_left == 0) begin
                  void'(q.pop_front());
                  done++;
                  rb    = ~rb;
                  phase = 0;
               end
            end
         endcase
         vectors++;
         if (WrReady !== (q.size() < 2) || WrBank !== wb || RdBank !== rb ||
             Idle !== (q.size() == 0) || Overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_status: cycle %0d WrReady=%b WrBank=%b RdBank=%b Idle=%b Ovf=%b expected %b %b %b %b 0",
                     cyc, WrReady, WrBank, RdBank, Idle, Overflow,
                     q.size() < 2, wb, rb, q.size() == 0);
         end
         armed = (phase == 0) && (q.size() > 0);
      end
      ConvRead = 1'b0;
      vectors++;
      if (done != N_STREAM) begin
         miscompares++;
         $display("FAIL stream_count: got %0d blocks expected %0d", done, N_STREAM);
      end
   endtask

`ifdef AQ_DJPEG_SCHED_STATS_EN
   task automatic test_stats();
      do_reset();
      StatClr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         write_block(rand_desc());
         tick();
         read_and_drain();
      end
      vectors++;
      if (BlockCount !== 24'd5) begin
         miscompares++;
         $display("FAIL stats_count: got %0d expected 5", BlockCount);
      end
      write_block(rand_desc());
      tick();
      ConvRead = 1'b1;
      repeat (READ_LEN) tick();
      ConvRead = 1'b0;
      for (int i = 1; i <= DRAIN + 2; i++) begin
         StatClr = (i >= DRAIN + 1);
         tick();
      end
      StatClr = 1'b0;
      vectors++;
      if (BlockCount !== 24'd0) begin
         miscompares++;
         $display("FAIL stats_clr: got %0d expected 0", BlockCount);
      end
      write_block(rand_desc());
      tick();
      read_and_drain();
      vectors++;
      if (BlockCount !== 24'd1) begin
         miscompares++;
         $display("FAIL stats_after_clr: got %0d expected 1", BlockCount);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_block();
      test_back_to_back();
      test_overflow();
      test_timeout();
      test_reset_mid_run();
      test_random_stream();
`ifdef AQ_DJPEG_SCHED_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
